vga_pixel_capture: RTL
======================

VGA_PIXEL_CAPTURE -- requirements
Module: vga_pixel_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 SHALL have port clk  input  1  pixel clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports rojo/verde/azul  input  3/3/2  RGB332 pixel sampled from the video output pins.
REQ-006 SHALL have port blank  input  1  1 = blanking interval, 0 = active pixel.
REQ-007 SHALL have port vsync  input  1  active-low frame sync.
REQ-008 SHALL have port arm  input  1  single-cycle request to capture the next frame.
REQ-009 SHALL have ports pix_data  output  8  {azul,verde,rojo}; pix_mask  output  3  {b,g,r} channel-nonzero flags.
REQ-010 SHALL have ports pix_x  output  10 and pix_y  output  9  coordinates of pix_data.
REQ-011 SHALL have ports pix_valid  output  1 and pix_ready  input  1  valid/ready handshake.
REQ-012 SHALL have ports busy  output  1; frame_done  output  1 (one-cycle pulse); overflow  output  1 (sticky).

Function
REQ-013 SHALL register all video inputs once before use (input stage, 1 cycle).
REQ-014 SHALL implement FSM IDLE -> WAIT_VS on arm; WAIT_VS -> CAPTURE on registered vsync 1->0; CAPTURE -> DONE after pixel (H_ACTIVE-1, V_ACTIVE-1) is pushed; DONE -> IDLE after one cycle.
REQ-015 SHALL assert busy in WAIT_VS and CAPTURE; frame_done for exactly the DONE cycle.
REQ-016 SHALL ignore arm outside IDLE.
REQ-017 In CAPTURE, every registered sample with blank=0 SHALL be pushed with current x,y; x increments per push.
REQ-018 On registered blank 0->1, x SHALL clear to 0 and y SHALL increment; samples with blank=1 are never pushed.
REQ-019 pix_mask SHALL be {|azul,|verde,|rojo} of the pushed pixel.
REQ-020 SHALL buffer pushed pixels in a 2-entry FIFO; pix_valid = FIFO non-empty; entry pops when pix_valid && pix_ready.
REQ-021 Latency: video input at edge n SHALL appear with pix_valid at edge n+2 when FIFO empty.
REQ-022 Push with FIFO full and no pop in the same cycle SHALL drop the pixel and set overflow; push and pop in the same cycle on a full FIFO SHALL succeed.
REQ-023 overflow SHALL clear only on arm accepted in IDLE, or reset.
REQ-024 vsync 1->0 during CAPTURE SHALL restart the frame: x=y=0, FIFO flushed, no frame_done, overflow unchanged.
REQ-025 x, y SHALL saturate at H_ACTIVE-1 / V_ACTIVE-1 (extra active samples on a line set overflow and are dropped).
REQ-026 FIFO contents SHALL drain normally after DONE.

Reset
REQ-027 On rst_n=0: state IDLE, FIFO empty, x=y=0, pix_data/pix_mask/pix_x/pix_y=0, pix_valid=busy=frame_done=overflow=0, asynchronously.

Configuration
REQ-028 With CAP_STATS_EN defined: output nz_count (20 bits) = pixels pushed with pix_mask!=0 in the last completed frame, updated in DONE, reset 0, cleared internal accumulator on frame start/restart.
REQ-029 Without CAP_STATS_EN: no nz_count port, no accumulator logic.

Structure
REQ-030 Shared package SHALL hold FSM state encodings (IDLE, WAIT_VS, CAPTURE, DONE), RGB332 field widths, default H_ACTIVE/V_ACTIVE.
REQ-031 The 2-entry FIFO SHALL be sub-module cap_fifo2 (width 8+3+10+9).

Verification (H_ACTIVE=4, V_ACTIVE=2)
REQ-032 Arm, vsync pulse, two lines of pixels 0x01..0x08, ready=1 -> 8 outputs in order, coords (0,0)..(3,1), frame_done once, overflow=0.
REQ-033 Same with ready=0 for whole frame -> 2 pixels held (0x01,0x02), overflow=1; raise ready -> exactly those 2 drain.
REQ-034 Pixel 0xC0 -> pix_mask=3'b100; 0x00 -> 3'b000; 0x07 -> 3'b001.
REQ-035 vsync 1->0 after 3 pixels -> FIFO flushed, next pixel reported at (0,0), single frame_done at true end.
REQ-036 rst_n low mid-CAPTURE -> all outputs 0 immediately, IDLE; arm during CAPTURE ignored.
REQ-037 CAP_STATS_EN: frame with 5 nonzero, 3 zero pixels -> nz_count=5 at frame_done.

Source files
------------

// File: rtl/vga_pixel_capture_pkg.sv
// Shared definitions for the VGA pixel capture block.
//   - Capture FSM state encoding (IDLE, WAIT_VS, CAPTURE, DONE)
//   - RGB332 field widths and coordinate widths
//   - Default active-area geometry (640x480)
//   - Packed layout of one captured pixel as it travels through the FIFO
package vga_pixel_capture_pkg;

  localparam int R_W = 3;  // rojo
  localparam int G_W = 3;  // verde
  localparam int B_W = 2;  // azul
  localparam int PIX_W = R_W + G_W + B_W;
  localparam int MASK_W = 3;
  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  // One FIFO entry: coordinates, channel-nonzero mask and the pixel itself.
  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [MASK_W-1:0] mask;
    logic [PIX_W-1:0]  data;
  } cap_entry_t;

  localparam int ENTRY_W = $bits(cap_entry_t);

  // Channel-nonzero flags of an RGB332 byte laid out {azul,verde,rojo}.
  function automatic logic [MASK_W-1:0] pix_mask_of(input logic [PIX_W-1:0] p);
    return {|p[PIX_W-1 -: B_W], |p[R_W+G_W-1 -: G_W], |p[R_W-1:0]};
  endfunction

endpackage

// File: rtl/vga_pixel_capture_fifo2.sv
// cap_fifo2: two-entry synchronous FIFO carrying captured pixels.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (storage cleared too,
//                 so the head output reads zero out of reset)
//   push, din   - write one entry; caller guarantees !full || pop
//   pop         - remove the head entry; caller guarantees !empty
//   flush       - discard all entries; overrides push and pop
//   dout        - head entry (only meaningful while valid)
//   valid, full - occupancy flags
module cap_fifo2 #(
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic         full
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = (count != 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/vga_pixel_capture.sv
// vga_pixel_capture: snoops an RGB332 VGA output and captures one frame of
// active pixels on request, handing them out over a valid/ready stream.
//
// Optional feature: define CAP_STATS_EN to add nz_count, the number of pushed
// pixels with a nonzero channel mask in the last completed frame.
//
// Ports:
//   clk, rst_n              - pixel clock, asynchronous active-low reset
//   rojo, verde, azul       - RGB332 pixel from the video pins
//   blank                   - 1 = blanking, 0 = active pixel
//   vsync                   - active-low frame sync
//   arm                     - one-cycle request to capture the next frame
//   pix_data/mask/x/y       - captured pixel {azul,verde,rojo}, {b,g,r} nonzero
//                             flags, and its coordinates
//   pix_valid, pix_ready    - output stream handshake
//   busy, frame_done        - capture in progress / one-cycle end-of-frame pulse
//   overflow                - sticky: a pixel was dropped this capture
//   dbg_state               - current FSM state
//   nz_count                - (CAP_STATS_EN only) nonzero-pixel count
//
// Handshake: a pixel transfers on every rising edge where pix_valid and
// pix_ready are both 1; pix_valid never depends on pix_ready, and the pixel
// fields hold steady while pix_valid is 1 and no transfer has happened.
module vga_pixel_capture
  import vga_pixel_capture_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [R_W-1:0]    rojo,
  input  logic [G_W-1:0]    verde,
  input  logic [B_W-1:0]    azul,
  input  logic              blank,
  input  logic              vsync,
  input  logic              arm,
  output logic [PIX_W-1:0]  pix_data,
  output logic [MASK_W-1:0] pix_mask,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output cap_state_t        dbg_state
`ifdef CAP_STATS_EN
  ,
  output logic [19:0]       nz_count
`endif
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

  // Input stage plus one extra tap on the controls for edge detection.
  logic [PIX_W-1:0] pix_q;
  logic             blank_q, blank_d;
  logic             vsync_q, vsync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q   <= '0;
      blank_q <= 1'b1;
      blank_d <= 1'b1;
      vsync_q <= 1'b1;
      vsync_d <= 1'b1;
    end else begin
      pix_q   <= {azul, verde, rojo};
      blank_q <= blank;
      blank_d <= blank_q;
      vsync_q <= vsync;
      vsync_d <= vsync_q;
    end
  end

  cap_state_t     state;
  logic [X_W-1:0] x_cnt;
  logic [Y_W-1:0] y_cnt;
  logic           line_full;  // position H_ACTIVE-1 of this line already taken

  logic       vs_fall, blank_rise, restart, sample;
  logic       cap_push, sat_drop, fifo_push, fifo_drop, pop, last_pix;
  logic       fifo_full;
  cap_entry_t wr_entry, head;

  always_comb begin
    vs_fall    = vsync_d & ~vsync_q;
    blank_rise = blank_q & ~blank_d;
    // A new vsync inside CAPTURE restarts the frame; that cycle pushes nothing.
    restart    = (state == ST_CAPTURE) && vs_fall;
    sample     = (state == ST_CAPTURE) && !restart && !blank_q;
    cap_push   = sample && !line_full;
    sat_drop   = sample && line_full;
    pop        = pix_valid && pix_ready;
    fifo_push  = cap_push && (!fifo_full || pop);
    fifo_drop  = cap_push && fifo_full && !pop;
    // The frame ends on the last coordinate even if the FIFO had to drop it.
    last_pix   = cap_push && (x_cnt == X_LAST) && (y_cnt == Y_LAST);

    wr_entry.x    = x_cnt;
    wr_entry.y    = y_cnt;
    wr_entry.mask = pix_mask_of(pix_q);
    wr_entry.data = pix_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      x_cnt      <= '0;
      y_cnt      <= '0;
      line_full  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arm) begin
            state    <= ST_WAIT_VS;
            busy     <= 1'b1;
            overflow <= 1'b0;
          end
        end
        ST_WAIT_VS: begin
          if (vs_fall) begin
            state     <= ST_CAPTURE;
            x_cnt     <= '0;
            y_cnt     <= '0;
            line_full <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (restart) begin
            x_cnt     <= '0;
            y_cnt     <= '0;
            line_full <= 1'b0;
          end else if (last_pix) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else if (blank_rise) begin
            x_cnt     <= '0;
            line_full <= 1'b0;
            if (y_cnt != Y_LAST) y_cnt <= y_cnt + 1'b1;
          end else if (cap_push) begin
            if (x_cnt == X_LAST) line_full <= 1'b1;
            else                 x_cnt     <= x_cnt + 1'b1;
          end
        end
        default: begin  // ST_DONE
          state <= ST_IDLE;
        end
      endcase
      if (fifo_drop || sat_drop) overflow <= 1'b1;
    end
  end

  assign dbg_state = state;

  cap_fifo2 #(.W(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (pop),
    .flush (restart),
    .din   (wr_entry),
    .dout  (head),
    .valid (pix_valid),
    .full  (fifo_full)
  );

  assign pix_data = head.data;
  assign pix_mask = head.mask;
  assign pix_x    = head.x;
  assign pix_y    = head.y;

`ifdef CAP_STATS_EN
  logic [19:0] nz_acc;
  logic        nz_inc;

  assign nz_inc = fifo_push && (wr_entry.mask != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_acc   <= '0;
      nz_count <= '0;
    end else begin
      if (((state == ST_WAIT_VS) && vs_fall) || restart) nz_acc <= '0;
      else if (nz_inc)                                    nz_acc <= nz_acc + 1'b1;
      // Published as the state enters DONE, so it is stable alongside frame_done.
      if (last_pix) nz_count <= nz_acc + {19'd0, nz_inc};
    end
  end
`endif

endmodule
